// File: rtl/reg_read_pipe.sv
// ---------------------------------------------------------------------------
// reg_read_pipe
//
// Register-read pipeline stage between decode and execute. It holds the
// architectural register file, which has two write ports:
//   - a general write-back port (write / writeAdd / in)
//   - a dedicated PC port that always targets register PC_REG (writeR7 / inR7)
// Both operands and their equality flag are registered into a single
// valid/ready output slot that feeds execute.
//
// Optional feature (compile-time macro):
//   REG_READ_BYPASS_EN - when defined, a read whose address matches a write
//                        in the same cycle returns the new data. Priority is
//                        general write, then PC write, then the stored value.
//                        When undefined, reads return the stored pre-edge
//                        value, and decode must insert one bubble after a
//                        write-back to a source register.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   decode presents a read request
//   in_ready   out  stage accepts the request this cycle
//   readAdd1   in   operand 1 register address
//   readAdd2   in   operand 2 register address
//   write      in   general write-back enable
//   writeAdd   in   general write-back address
//   in         in   general write-back data
//   writeR7    in   PC register write enable
//   inR7       in   PC register write data
//   out_valid  out  output slot holds a valid operand pair
//   out_ready  in   execute consumes the slot this cycle
//   regValue1  out  registered operand 1
//   regValue2  out  registered operand 2
//   equalValue out  registered (regValue1 == regValue2)
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holding valid keeps its
// payload stable until the transfer; ready never depends on valid.
// Here in_ready = !reset && (!out_valid || out_ready), so a full slot that
// is being drained accepts a new request in the same cycle (no bubble).
// ---------------------------------------------------------------------------
module reg_read_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int PC_REG = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] readAdd1,
  input  logic [ADDR_W-1:0] readAdd2,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeAdd,
  input  logic [DATA_W-1:0] in,
  input  logic              writeR7,
  input  logic [DATA_W-1:0] inR7,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] regValue1,
  output logic [DATA_W-1:0] regValue2,
  output logic              equalValue
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

  // Register file and output slot state
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] value1_q, value1_d;
  logic [DATA_W-1:0] value2_q, value2_d;
  logic              equal_q, equal_d;

  logic              transfer;
  logic [DATA_W-1:0] rd1, rd2;

  // Read one port. With the bypass enabled the new write data is forwarded
  // using the same priority the register file uses when both ports hit
  // PC_REG: the general port wins over the PC port.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
`ifdef REG_READ_BYPASS_EN
    if (write && (writeAdd == addr)) begin
      val = in;
    end else if (writeR7 && (addr == PC_ADDR)) begin
      val = inR7;
    end else begin
      val = regs_q[addr];
    end
`else
    val = regs_q[addr];
`endif
    return val;
  endfunction

  assign rd1 = read_port(readAdd1);
  assign rd2 = read_port(readAdd2);

  assign in_ready = !reset && (!out_valid_q || out_ready);
  assign transfer = in_valid && in_ready;

  // Register file next state. The PC port is applied first so that a
  // general write to PC_REG in the same cycle overrides it.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (writeR7) begin
      regs_d[PC_ADDR] = inR7;
    end
    if (write) begin
      regs_d[writeAdd] = in;
    end
  end

  // Output slot next state. Captured data is only replaced on a transfer,
  // so a stalled slot is immune to later register writes.
  always_comb begin
    out_valid_d = out_valid_q;
    value1_d    = value1_q;
    value2_d    = value2_q;
    equal_d     = equal_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      value1_d    = rd1;
      value2_d    = rd2;
      equal_d     = (rd1 == rd2);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Reset clears everything and drops any write presented in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      value1_q    <= '0;
      value2_q    <= '0;
      equal_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      out_valid_q <= out_valid_d;
      value1_q    <= value1_d;
      value2_q    <= value2_d;
      equal_q     <= equal_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign regValue1  = value1_q;
  assign regValue2  = value2_q;
  assign equalValue = equal_q;

endmodule

// File: tb/tb_reg_read_pipe.sv
// ---------------------------------------------------------------------------
// tb_reg_read_pipe
//
// Directed bench for reg_read_pipe. A table of one-cycle vectors holds the
// inputs and the hand-computed in_ready (before the edge) and slot contents
// (after the edge); stall and reset corner cases follow as hand sequences.
// Expected values that depend on REG_READ_BYPASS_EN are selected with the
// same macro.
// ---------------------------------------------------------------------------
module tb_reg_read_pipe;

  localparam int DW = 16;
  localparam int AW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] readAdd1, readAdd2;
  logic          write;
  logic [AW-1:0] writeAdd;
  logic [DW-1:0] in;
  logic          writeR7;
  logic [DW-1:0] inR7;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] regValue1, regValue2;
  logic          equalValue;

  reg_read_pipe #(.DATA_W(DW), .ADDR_W(AW), .PC_REG(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .readAdd1   (readAdd1),
    .readAdd2   (readAdd2),
    .write      (write),
    .writeAdd   (writeAdd),
    .in         (in),
    .writeR7    (writeR7),
    .inR7       (inR7),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .regValue1  (regValue1),
    .regValue2  (regValue2),
    .equalValue (equalValue)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          iv;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          w7;
    logic [DW-1:0] d7;
    logic          ordy;
    logic          exp_ir;
    logic          exp_ov;
    logic [DW-1:0] exp_v1;
    logic [DW-1:0] exp_v2;
    logic          exp_eq;
  } vec_t;

`ifdef REG_READ_BYPASS_EN
  localparam logic [DW-1:0] V4_EXP  = 16'hBEEF;
  localparam logic [DW-1:0] V6_EXP  = 16'h0001;
  localparam logic          V6_EQ   = 1'b0;
  localparam logic [DW-1:0] V10_EXP = 16'h0F0F;
`else
  localparam logic [DW-1:0] V4_EXP  = 16'h0000;
  localparam logic [DW-1:0] V6_EXP  = 16'h0000;
  localparam logic          V6_EQ   = 1'b1;
  localparam logic [DW-1:0] V10_EXP = 16'h00AA;
`endif

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    reset    = v.rst;
    in_valid = v.iv;
    readAdd1 = v.ra1;
    readAdd2 = v.ra2;
    write    = v.we;
    writeAdd = v.wa;
    in       = v.wd;
    writeR7  = v.w7;
    inR7     = v.d7;
    out_ready = v.ordy;
  endtask

  // Drive on the falling edge, check in_ready before the rising edge, then
  // check the slot #1 after the rising edge.
  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check({tag, ".in_ready"}, DW'(in_ready), DW'(v.exp_ir));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, DW'(out_valid), DW'(v.exp_ov));
    check({tag, ".regValue1"}, regValue1, v.exp_v1);
    check({tag, ".regValue2"}, regValue2, v.exp_v2);
    check({tag, ".equalValue"}, DW'(equalValue), DW'(v.exp_eq));
  endtask

  initial begin
    vec_t v;
    //           rst  iv  ra1 ra2 we wa  wd        w7 d7        ordy ir ov v1       v2       eq
    // reset, write to r2 is dropped
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 3'd2, 16'h5555, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 16'h0,    16'h0,    1'b0};
    // read r0,r7 after reset
    vecs[1]  = '{1'b0, 1'b1, 3'd0, 3'd7, 1'b0, 3'd0, 16'h0,    1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 16'h0,    16'h0,    1'b1};
    // write r3, slot drains, data held
    vecs[2]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 16'h1234, 1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 16'h0,    16'h0,    1'b1};
    // read r3,r4
    vecs[3]  = '{1'b0, 1'b1, 3'd3, 3'd4, 1'b0, 3'd0, 16'h0,    1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 16'h1234, 16'h0,    1'b0};
    // same-cycle write r5 and read r5,r5
    vecs[4]  = '{1'b0, 1'b1, 3'd5, 3'd5, 1'b1, 3'd5, 16'hBEEF, 1'b0, 16'h0,    1'b1, 1'b1, 1'b1, V4_EXP,   V4_EXP,   1'b1};
    // r5 stored, r2 never written
    vecs[5]  = '{1'b0, 1'b1, 3'd5, 3'd2, 1'b0, 3'd0, 16'h0,    1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h0,    1'b0};
    // both ports write r7, general wins (bypass too)
    vecs[6]  = '{1'b0, 1'b1, 3'd7, 3'd6, 1'b1, 3'd7, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b1, V6_EXP,   16'h0,    V6_EQ};
    vecs[7]  = '{1'b0, 1'b1, 3'd7, 3'd7, 1'b0, 3'd0, 16'h0,    1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 16'h0001, 16'h0001, 1'b1};
    // PC port alone, slot drains
    vecs[8]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0,    1'b1, 16'h00AA, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0001, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 3'd7, 3'd3, 1'b0, 3'd0, 16'h0,    1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 16'h00AA, 16'h1234, 1'b0};
    // PC-port bypass
    vecs[10] = '{1'b0, 1'b1, 3'd7, 3'd1, 1'b0, 3'd0, 16'h0,    1'b1, 16'h0F0F, 1'b1, 1'b1, 1'b1, V10_EXP,  16'h0,    1'b0};
    // back-to-back transfers
    vecs[11] = '{1'b0, 1'b1, 3'd3, 3'd3, 1'b0, 3'd0, 16'h0,    1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 16'h1234, 16'h1234, 1'b1};
    // write r1 for the stall sequence
    vecs[12] = '{1'b0, 1'b1, 3'd4, 3'd4, 1'b1, 3'd1, 16'h0011, 1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 16'h0,    16'h0,    1'b1};

    v = vecs[0];
    drive(v);
    for (int i = 0; i < NVEC; i++) begin
      step($sformatf("v%0d", i), vecs[i]);
    end

    // Stall: slot captures r1, then execute stalls 3 cycles while r1 is
    // rewritten and decode waits with a pending request.
    v = '{1'b0, 1'b1, 3'd1, 3'd1, 1'b0, 3'd0, 16'h0,    1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0011, 16'h0011, 1'b1};
    step("stall_load", v);
    for (int i = 0; i < 3; i++) begin
      v = '{1'b0, 1'b1, 3'd3, 3'd1, 1'b1, 3'd1, 16'h0099, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0011, 16'h0011, 1'b1};
      step($sformatf("stall%0d", i), v);
    end
    // release: pending request transfers and sees the new r1
    v = '{1'b0, 1'b1, 3'd3, 3'd1, 1'b0, 3'd0, 16'h0,    1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0099, 1'b0};
    step("release", v);
    // idle with execute not ready: slot holds
    v = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0,    1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0099, 1'b0};
    step("hold", v);

    // Reset while the slot is valid and a write is presented.
    v = '{1'b1, 1'b1, 3'd6, 3'd6, 1'b1, 3'd6, 16'h7777, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0};
    step("rst_mid", v);
    // r6 write dropped, r3 cleared
    v = '{1'b0, 1'b1, 3'd6, 3'd3, 1'b0, 3'd0, 16'h0,    1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0, 1'b1};
    step("post_rst", v);

    @(negedge clk);
    in_valid = 1'b0;
    write    = 1'b0;
    writeR7  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
